// File: rtl/t03_dpu_nibble_streamer.sv
// Captures coordinate nibbles from the DPU or the register bank and holds them on a parallel bus.
// On request, it streams a snapshot of that bus nibble-by-nibble over a valid/ready link, ending with the player state.
module t03_dpu_nibble_streamer #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned COORD_W = 8,
  parameter int unsigned NIB_W   = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [N_CH*COORD_W-1:0]                   coord_in,
  input  logic [N_CH*COORD_W-1:0]                   reg_nib_in,
  input  logic [NIB_W-1:0]                          reg_state_in,
  input  logic                                      new_input_select,
  input  logic                                      register_input,
  output logic [N_CH*COORD_W-1:0]                   par_out,
  output logic [NIB_W-1:0]                          player_state_out,
  input  logic                                      stream_start,
  output logic                                      stream_valid,
  input  logic                                      stream_ready,
  output logic [NIB_W-1:0]                          stream_data,
  output logic [$clog2(N_CH*(COORD_W/NIB_W)+1)-1:0] stream_idx,
  output logic                                      stream_last,
  output logic                                      busy,
  output logic                                      done
);

  localparam int unsigned NIBS  = COORD_W / NIB_W;
  localparam int unsigned BEATS = N_CH * NIBS + 1;
  localparam int unsigned BUS_W = N_CH * COORD_W;
  localparam int unsigned SH_W  = BUS_W + NIB_W;
  localparam int unsigned IDX_W = $clog2(BEATS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  typedef enum logic {S_IDLE, S_STREAM} state_e;

  state_e            state_q, state_d;
  logic [BUS_W-1:0]  par_q, par_d;
  logic [NIB_W-1:0]  pst_q, pst_d;
  logic [SH_W-1:0]   shadow_q, shadow_d;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_nx;
  logic [NIB_W-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  int unsigned       nib_base;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      par_q    <= '0;
      pst_q    <= '0;
      shadow_q <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      par_q    <= par_d;
      pst_q    <= pst_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Capture path: DPU load has priority and leaves the player state untouched.
  always_comb begin
    par_d = par_q;
    pst_d = pst_q;
    if (new_input_select) begin
      par_d = coord_in;
    end else if (register_input) begin
      par_d = reg_nib_in;
      pst_d = reg_state_in;
    end
  end

  // Stream FSM; the shadow is packed {state, par} so the state lands on the final beat index.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    last_d   = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    idx_nx   = idx_q + IDX_W'(1);
    nib_base = 32'(idx_nx) * NIB_W;
    case (state_q)
      S_IDLE: begin
        if (stream_start) begin
          shadow_d = {pst_q, par_q};
          idx_d    = '0;
          data_d   = par_q[NIB_W-1:0];
          valid_d  = 1'b1;
          busy_d   = 1'b1;
          state_d  = S_STREAM;
        end
      end
      S_STREAM: begin
        valid_d = 1'b1;
        busy_d  = 1'b1;
        last_d  = last_q;
        if (stream_ready) begin
          if (last_q) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            idx_d   = '0;
          end else begin
            idx_d  = idx_nx;
            data_d = shadow_q[nib_base +: NIB_W];
            last_d = (idx_nx == LAST_IDX);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign par_out          = par_q;
  assign player_state_out = pst_q;
  assign stream_valid     = valid_q;
  assign stream_data      = data_q;
  assign stream_idx       = idx_q;
  assign stream_last      = last_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_t03_dpu_nibble_streamer.sv
// Bench for t03_dpu_nibble_streamer: table-driven capture vectors, directed stream sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_t03_dpu_nibble_streamer;

  localparam int unsigned N_CH    = 4;
  localparam int unsigned COORD_W = 8;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned BUS_W   = N_CH * COORD_W;
  localparam int unsigned BEATS   = N_CH * (COORD_W / NIB_W) + 1;
  localparam int unsigned IDX_W   = $clog2(BEATS);

  logic             clk = 1'b0;
  logic             rst;
  logic [BUS_W-1:0] coord_in, reg_nib_in, par_out;
  logic [NIB_W-1:0] reg_state_in, player_state_out, stream_data;
  logic             new_input_select, register_input, stream_start, stream_ready;
  logic             stream_valid, stream_last, busy, done;
  logic [IDX_W-1:0] stream_idx;

  t03_dpu_nibble_streamer #(.N_CH(N_CH), .COORD_W(COORD_W), .NIB_W(NIB_W)) dut (
    .clk(clk), .rst(rst), .coord_in(coord_in), .reg_nib_in(reg_nib_in),
    .reg_state_in(reg_state_in), .new_input_select(new_input_select),
    .register_input(register_input), .par_out(par_out),
    .player_state_out(player_state_out), .stream_start(stream_start),
    .stream_valid(stream_valid), .stream_ready(stream_ready), .stream_data(stream_data),
    .stream_idx(stream_idx), .stream_last(stream_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: snapshot held as a queue of beats plus a read position.
  logic [BUS_W-1:0] m_par;
  logic [NIB_W-1:0] m_st;
  logic [NIB_W-1:0] m_beats[$];
  int               m_pos;
  bit               m_stream;
  bit               m_done;

  task automatic model_update();
    logic [BUS_W-1:0] n_par;
    logic [NIB_W-1:0] n_st;
    if (!rst) begin
      m_par = '0; m_st = '0; m_beats.delete(); m_pos = 0; m_stream = 0; m_done = 0;
    end else begin
      n_par = m_par; n_st = m_st;
      if (new_input_select) n_par = coord_in;
      else if (register_input) begin n_par = reg_nib_in; n_st = reg_state_in; end
      m_done = 0;
      if (!m_stream) begin
        if (stream_start) begin
          m_beats.delete();
          for (int k = 0; k < BEATS - 1; k++) m_beats.push_back(m_par[k*NIB_W +: NIB_W]);
          m_beats.push_back(m_st);
          m_pos = 0;
          m_stream = 1;
        end
      end else if (stream_ready) begin
        if (m_pos == BEATS - 1) begin m_stream = 0; m_pos = 0; m_done = 1; end
        else m_pos++;
      end
      m_par = n_par; m_st = n_st;
    end
  endtask

  // Advance one clock with the currently driven inputs, then compare against the model.
  task automatic tick();
    model_update();
    @(posedge clk);
    @(negedge clk);
    chk("par_out", par_out, m_par);
    chk("player_state", player_state_out, m_st);
    chk("valid", stream_valid, m_stream);
    chk("busy", busy, m_stream);
    chk("done", done, m_done);
    chk("idx", stream_idx, m_pos);
    chk("last", stream_last, m_stream && (m_pos == BEATS - 1));
    if (m_stream) chk("data", stream_data, m_beats[m_pos]);
  endtask

  task automatic idle_inputs();
    new_input_select = 0; register_input = 0; stream_start = 0; stream_ready = 0;
  endtask

  typedef struct {
    logic             nis;
    logic             ri;
    logic [BUS_W-1:0] coord;
    logic [BUS_W-1:0] regnib;
    logic [NIB_W-1:0] regst;
    logic [BUS_W-1:0] exp_par;
    logic [NIB_W-1:0] exp_st;
  } vec_t;

  vec_t             vecs[$];
  logic [NIB_W-1:0] exp_beats[BEATS];
  logic [NIB_W-1:0] acc[$];
  logic [NIB_W-1:0] prev_data;
  logic [IDX_W-1:0] prev_idx;
  bit               stalled, finished;
  int               hold_cnt;

  task automatic check_acc(input string name);
    chk({name, "_count"}, acc.size(), BEATS);
    for (int i = 0; i < acc.size() && i < BEATS; i++) chk({name, "_beat"}, acc[i], exp_beats[i]);
  endtask

  initial begin
    rst = 0; idle_inputs();
    coord_in = '0; reg_nib_in = '0; reg_state_in = '0;
    exp_beats = '{4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h9};

    // Reset held two clocks with random inputs
    for (int i = 0; i < 2; i++) begin
      coord_in = $urandom; reg_nib_in = $urandom; reg_state_in = NIB_W'($urandom);
      new_input_select = 1'($urandom); register_input = 1'($urandom);
      stream_start = 1'($urandom); stream_ready = 1'($urandom);
      tick();
    end
    chk("rst_par", par_out, 0);
    chk("rst_state", player_state_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", stream_valid, 0);
    chk("rst_data", stream_data, 0);
    rst = 1; idle_inputs();
    tick();

    // Capture vectors: DPU load, hold, register load, priority, reload
    vecs.push_back('{1, 0, 32'hD4C3B2A1, 32'h0, 4'h0, 32'hD4C3B2A1, 4'h0});
    for (int i = 0; i < 5; i++) vecs.push_back('{0, 0, 32'h0, 32'hFFFF0000, 4'h7, 32'hD4C3B2A1, 4'h0});
    vecs.push_back('{0, 1, 32'h0, 32'h12345678, 4'h9, 32'h12345678, 4'h9});
    vecs.push_back('{1, 1, 32'hCAFEBABE, 32'h11111111, 4'h3, 32'hCAFEBABE, 4'h9});
    vecs.push_back('{0, 1, 32'h0, 32'h12345678, 4'h9, 32'h12345678, 4'h9});
    foreach (vecs[i]) begin
      new_input_select = vecs[i].nis; register_input = vecs[i].ri;
      coord_in = vecs[i].coord; reg_nib_in = vecs[i].regnib; reg_state_in = vecs[i].regst;
      tick();
      chk("vec_par", par_out, vecs[i].exp_par);
      chk("vec_state", player_state_out, vecs[i].exp_st);
    end
    idle_inputs();

    // Full-rate stream of the held snapshot
    stream_start = 1; stream_ready = 1;
    tick();
    stream_start = 0;
    for (int b = 0; b < BEATS; b++) begin
      chk("fr_data", stream_data, exp_beats[b]);
      chk("fr_last", stream_last, b == BEATS - 1);
      chk("fr_done", done, 0);
      tick();
    end
    chk("fr_done_pulse", done, 1);
    chk("fr_idx_zero", stream_idx, 0);
    stream_ready = 0;
    tick();
    chk("fr_done_clear", done, 0);

    // Backpressure: alternating ready plus a 6-cycle stall at idx 3
    stream_start = 1; tick(); stream_start = 0;
    acc.delete(); hold_cnt = 0; finished = 0;
    for (int c = 0; c < 80 && !finished; c++) begin
      if (stream_idx == 3 && hold_cnt < 6) begin stream_ready = 0; hold_cnt++; end
      else stream_ready = (c % 2 == 0);
      stalled = stream_valid && !stream_ready;
      prev_data = stream_data; prev_idx = stream_idx;
      if (stream_valid && stream_ready) acc.push_back(stream_data);
      tick();
      if (stalled) begin
        chk("bp_stall_data", stream_data, prev_data);
        chk("bp_stall_idx", stream_idx, prev_idx);
      end
      if (done) finished = 1;
    end
    chk("bp_finished", finished, 1);
    chk("bp_long_stall", hold_cnt, 6);
    check_acc("bp");
    idle_inputs(); tick();

    // Start and load in the same cycle; mid-stream start ignored
    stream_start = 1; register_input = 1; reg_nib_in = 32'hFFFFFFFF; reg_state_in = 4'hA;
    tick();
    chk("sl_par", par_out, 32'hFFFFFFFF);
    chk("sl_state", player_state_out, 4'hA);
    stream_start = 0; register_input = 0; stream_ready = 1;
    acc.delete(); finished = 0;
    for (int c = 0; c < 20 && !finished; c++) begin
      stream_start = (c >= 3 && c <= 5);
      if (stream_valid && stream_ready) acc.push_back(stream_data);
      tick();
      if (done) finished = 1;
    end
    chk("sl_finished", finished, 1);
    check_acc("sl");
    stream_start = 0; tick();
    chk("sl_not_queued", stream_valid, 0);

    // Reset at beat 4 aborts with no done pulse
    register_input = 1; reg_nib_in = 32'h12345678; reg_state_in = 4'h9; tick();
    register_input = 0; stream_start = 1; stream_ready = 1; tick();
    stream_start = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("ab_idx4", stream_idx, 4);
    rst = 0; tick();
    chk("ab_valid", stream_valid, 0);
    chk("ab_idx", stream_idx, 0);
    chk("ab_par", par_out, 0);
    rst = 1; tick();
    chk("ab_no_done", done, 0);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 59) != 0);
      new_input_select = ($urandom_range(0, 7) == 0);
      register_input = ($urandom_range(0, 5) == 0);
      stream_start = ($urandom_range(0, 3) == 0);
      stream_ready = 1'($urandom);
      coord_in = $urandom; reg_nib_in = $urandom; reg_state_in = NIB_W'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
